// File: rtl/hier_collect_pkg.sv
// Shared types and helpers for the hierarchical result collector.
package hier_collect_pkg;

  // Width of a source index tag carried alongside each collected word.
  localparam int SRC_ID_W = 3;

  // Word width of a collected entry as seen by the shared entry type.
  localparam int ENTRY_DATA_W = 16;

  typedef logic [SRC_ID_W-1:0] src_id_t;

  typedef struct packed {
    src_id_t                 src;
    logic [ENTRY_DATA_W-1:0] data;
  } collect_entry_t;

  // Increment a source index, wrapping to 0 when it reaches n.
  function automatic src_id_t rr_next(input src_id_t idx, input int unsigned n);
    src_id_t nxt;
    if ((int'(idx) + 1) >= int'(n)) begin
      nxt = '0;
    end else begin
      nxt = idx + src_id_t'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/hier_collect_rr_arbiter.sv
// Round-robin arbiter: scans requests starting at an internal pointer and
// moves the pointer just past the winner whenever a grant is taken.
module hier_rr_arbiter #(
  parameter int NUM_SRC = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] req_i,
  input  logic               en_i,
  output logic [NUM_SRC-1:0] gnt_o,
  output logic [2:0]         gnt_idx_o,
  output logic               gnt_any_o
);
  import hier_collect_pkg::*;

  src_id_t    rr_ptr_q;
  src_id_t    rr_ptr_d;
  logic [3:0] cand_sum;
  logic       cand_req;

  // Pick the first requester at or after rr_ptr, wrapping modulo NUM_SRC.
  always_comb begin
    gnt_any_o = 1'b0;
    gnt_idx_o = '0;
    cand_sum  = '0;
    cand_req  = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand_sum = {1'b0, rr_ptr_q} + 4'(k);
      if (cand_sum >= 4'(NUM_SRC)) begin
        cand_sum = cand_sum - 4'(NUM_SRC);
      end
      cand_req = 1'b0;
      for (int j = 0; j < NUM_SRC; j++) begin
        if (cand_sum == 4'(j)) begin
          cand_req = req_i[j];
        end
      end
      if (!gnt_any_o && cand_req) begin
        gnt_any_o = 1'b1;
        gnt_idx_o = cand_sum[2:0];
      end
    end
  end

  // Expand the winning index into a one-hot grant vector.
  always_comb begin
    gnt_o = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      gnt_o[i] = gnt_any_o && (gnt_idx_o == 3'(i));
    end
  end

  // Pointer advances only when the grant is actually taken.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (en_i && gnt_any_o) begin
      rr_ptr_d = rr_next(gnt_idx_o, NUM_SRC);
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/hier_result_collector.sv
// Gathers result words from NUM_SRC child streams, tags each with its
// source index and queues it in a 2-entry FIFO toward the parent.
//
// Handshake: on every port a word moves when valid && ready are both high at
// a rising edge; a source holds valid and data stable until it is accepted,
// and src_ready never depends combinationally on out_ready.
module hier_result_collector #(
  parameter int NUM_SRC = 5,
  parameter int DATA_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [2:0]                out_src,
  output logic [15:0]               accept_cnt
);
  import hier_collect_pkg::*;

  logic [NUM_SRC-1:0] gnt;
  logic [2:0]         gnt_idx;
  logic               gnt_any;
  logic               arb_en;
  logic               push;
  logic               pop;
  logic [DATA_W-1:0]  push_data;

  // FIFO storage: head is presented on the output, tail is the second slot.
  src_id_t           head_src_q, head_src_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  src_id_t           tail_src_q, tail_src_d;
  logic [DATA_W-1:0] tail_data_q, tail_data_d;
  logic [1:0]        count_q, count_d;
  logic [15:0]       accept_cnt_q, accept_cnt_d;

  // A push is offered only when a slot is free; reset also silences ready.
  assign arb_en    = rst_n && (count_q != 2'd2);
  assign push      = arb_en && gnt_any;
  assign pop       = (count_q != 2'd0) && out_ready;
  assign src_ready = gnt & {NUM_SRC{arb_en}};

  assign out_valid  = (count_q != 2'd0);
  assign out_data   = head_data_q;
  assign out_src    = head_src_q;
  assign accept_cnt = accept_cnt_q;

  hier_rr_arbiter #(
    .NUM_SRC (NUM_SRC)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (src_valid),
    .en_i      (arb_en),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  // Select the granted source's word from the packed data bus.
  always_comb begin
    push_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt[i]) begin
        push_data = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // FIFO next state; the head keeps its last value when the FIFO empties.
  always_comb begin
    head_src_d   = head_src_q;
    head_data_d  = head_data_q;
    tail_src_d   = tail_src_q;
    tail_data_d  = tail_data_q;
    count_d      = count_q;
    accept_cnt_d = accept_cnt_q;
    if (push) begin
      accept_cnt_d = accept_cnt_q + 16'd1;
    end
    case ({push, pop})
      2'b11: begin
        // Only reachable at count 1: the new word replaces the leaving head.
        head_src_d  = gnt_idx;
        head_data_d = push_data;
      end
      2'b10: begin
        if (count_q == 2'd0) begin
          head_src_d  = gnt_idx;
          head_data_d = push_data;
        end else begin
          tail_src_d  = gnt_idx;
          tail_data_d = push_data;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        if (count_q == 2'd2) begin
          head_src_d  = tail_src_q;
          head_data_d = tail_data_q;
        end
        count_d = count_q - 2'd1;
      end
      default: begin
      end
    endcase
  end

  // FIFO and accept counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_src_q   <= '0;
      head_data_q  <= '0;
      tail_src_q   <= '0;
      tail_data_q  <= '0;
      count_q      <= '0;
      accept_cnt_q <= '0;
    end else begin
      head_src_q   <= head_src_d;
      head_data_q  <= head_data_d;
      tail_src_q   <= tail_src_d;
      tail_data_q  <= tail_data_d;
      count_q      <= count_d;
      accept_cnt_q <= accept_cnt_d;
    end
  end

endmodule

// File: tb/tb_hier_result_collector.sv
// Directed bench for hier_result_collector: vector table plus hand-written
// reset and fairness sequences.
module tb_hier_result_collector;

  localparam int NUM_SRC = 5;
  localparam int DATA_W  = 16;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_ready;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_data;
  logic [2:0]                out_src;
  logic [15:0]               accept_cnt;

  int total = 0;
  int bad   = 0;

  logic [18:0] exp_q[$];

  typedef struct {
    logic [4:0]  valid;
    logic        ordy;
    logic [4:0]  ready;
    logic        ov;
    logic [2:0]  src;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[21];

  hier_result_collector #(
    .NUM_SRC (NUM_SRC),
    .DATA_W  (DATA_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_src    (out_src),
    .accept_cnt (accept_cnt)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin
    logic [18:0] e;
    int          pops;

    // Each source always presents 0x1000 + its index.
    for (int i = 0; i < NUM_SRC; i++) begin
      src_data[i*DATA_W +: DATA_W] = 16'h1000 + 16'(i);
    end

    //             valid     ordy  ready     ov    src   cnt
    vecs[0]  = '{5'b11111, 1'b1, 5'b00001, 1'b0, 3'd0, 16'd0};
    vecs[1]  = '{5'b11111, 1'b1, 5'b00010, 1'b1, 3'd0, 16'd1};
    vecs[2]  = '{5'b11111, 1'b1, 5'b00100, 1'b1, 3'd1, 16'd2};
    vecs[3]  = '{5'b11111, 1'b1, 5'b01000, 1'b1, 3'd2, 16'd3};
    vecs[4]  = '{5'b11111, 1'b1, 5'b10000, 1'b1, 3'd3, 16'd4};
    vecs[5]  = '{5'b11111, 1'b1, 5'b00001, 1'b1, 3'd4, 16'd5};
    vecs[6]  = '{5'b00000, 1'b1, 5'b00000, 1'b1, 3'd0, 16'd6};
    vecs[7]  = '{5'b01010, 1'b1, 5'b00010, 1'b0, 3'd0, 16'd6};
    vecs[8]  = '{5'b01010, 1'b1, 5'b01000, 1'b1, 3'd1, 16'd7};
    vecs[9]  = '{5'b01010, 1'b1, 5'b00010, 1'b1, 3'd3, 16'd8};
    vecs[10] = '{5'b01010, 1'b1, 5'b01000, 1'b1, 3'd1, 16'd9};
    vecs[11] = '{5'b10000, 1'b1, 5'b10000, 1'b1, 3'd3, 16'd10};
    vecs[12] = '{5'b00011, 1'b1, 5'b00001, 1'b1, 3'd4, 16'd11};
    vecs[13] = '{5'b00000, 1'b1, 5'b00000, 1'b1, 3'd0, 16'd12};
    vecs[14] = '{5'b10100, 1'b0, 5'b00100, 1'b0, 3'd0, 16'd12};
    vecs[15] = '{5'b10100, 1'b0, 5'b10000, 1'b1, 3'd2, 16'd13};
    vecs[16] = '{5'b10100, 1'b0, 5'b00000, 1'b1, 3'd2, 16'd14};
    vecs[17] = '{5'b10100, 1'b0, 5'b00000, 1'b1, 3'd2, 16'd14};
    vecs[18] = '{5'b10100, 1'b1, 5'b00000, 1'b1, 3'd2, 16'd14};
    vecs[19] = '{5'b00000, 1'b1, 5'b00000, 1'b1, 3'd4, 16'd14};
    vecs[20] = '{5'b00000, 1'b1, 5'b00000, 1'b0, 3'd0, 16'd14};

    // Reset held for 3 cycles with every source valid.
    rst_n     = 1'b0;
    src_valid = '1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("rst_ready", 32'(src_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_cnt", 32'(accept_cnt), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_src", 32'(out_src), 32'd0);
    end

    // Table: round-robin, skip idle, wrap, backpressure and drain.
    for (int v = 0; v < 21; v++) begin
      @(negedge clk);
      rst_n     = 1'b1;
      src_valid = vecs[v].valid;
      out_ready = vecs[v].ordy;
      #1;
      chk($sformatf("vec%0d_ready", v), 32'(src_ready), 32'(vecs[v].ready));
      chk($sformatf("vec%0d_out_valid", v), 32'(out_valid), 32'(vecs[v].ov));
      chk($sformatf("vec%0d_cnt", v), 32'(accept_cnt), 32'(vecs[v].cnt));
      if (vecs[v].ov) begin
        chk($sformatf("vec%0d_out_src", v), 32'(out_src), 32'(vecs[v].src));
        chk($sformatf("vec%0d_out_data", v), 32'(out_data),
            32'(16'h1000 + 16'(vecs[v].src)));
      end
    end

    // Reset with the FIFO full and rr_ptr parked at 4.
    @(negedge clk);
    src_valid = 5'b01000;
    out_ready = 1'b0;
    #1;
    chk("mid_ready1", 32'(src_ready), 32'b01000);
    @(negedge clk);
    #1;
    chk("mid_ready2", 32'(src_ready), 32'b01000);
    chk("mid_src2", 32'(out_src), 32'd3);
    chk("mid_cnt2", 32'(accept_cnt), 32'd15);
    @(negedge clk);
    src_valid = 5'b11111;
    #1;
    chk("mid_full_ready", 32'(src_ready), 32'd0);
    chk("mid_full_cnt", 32'(accept_cnt), 32'd16);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_cnt", 32'(accept_cnt), 32'd0);
    chk("mid_rst_ready", 32'(src_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("mid_first_grant", 32'(src_ready), 32'b00001);
    @(negedge clk);
    src_valid = '0;
    #1;
    chk("mid_after_valid", 32'(out_valid), 32'd1);
    chk("mid_after_src", 32'(out_src), 32'd0);
    chk("mid_after_data", 32'(out_data), 32'h1000);
    chk("mid_after_cnt", 32'(accept_cnt), 32'd1);

    // Fairness under random output stalls: all sources always valid, so the
    // output order must be 0,1,2,3,4,0,... regardless of stalls.
    for (int i = 0; i < 100; i++) begin
      exp_q.push_back({3'(i % NUM_SRC), 16'h1000 + 16'(i % NUM_SRC)});
    end
    pops = 0;
    @(negedge clk);
    rst_n = 1'b0;
    src_valid = '1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c != 0) @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      chk("fair_onehot", 32'($onehot0(src_ready)), 32'd1);
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        chk("fair_src", 32'(out_src), 32'(e[18:16]));
        chk("fair_data", 32'(out_data), 32'(e[15:0]));
        pops++;
      end
    end
    for (int d = 0; d < 10; d++) begin
      @(negedge clk);
      src_valid = '0;
      out_ready = 1'b1;
      #1;
      if (!out_valid) break;
      e = exp_q.pop_front();
      chk("drain_src", 32'(out_src), 32'(e[18:16]));
      chk("drain_data", 32'(out_data), 32'(e[15:0]));
      pops++;
    end
    chk("drain_empty", 32'(out_valid), 32'd0);
    chk("drain_cnt", 32'(accept_cnt), 32'(pops));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
